// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited request path, in-order response queue, redirect squashing.
// Optional FETCH_BYPASS_EN lets a response reach decode combinationally when the queue is empty.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic {FETCH, HALTED} state_t;

    state_t        state;
    logic [31:0]   fetch_ptr;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;

    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [AW-1:0] q_rd;
    logic [AW-1:0] q_wr;

    logic [31:0]   tag_mem [DEPTH];
    logic [AW-1:0] tag_rd;
    logic [AW-1:0] tag_wr;

    logic          grant;
    logic          resp_keep;
    logic          bypass;
    logic          enq;
    logic          pop_q;
    logic [31:0]   resp_tag;
    logic [CW:0]   in_use;
    logic [CW-1:0] outstanding_nxt;

    // Credits cover both queued entries and requests still in flight, so a response always has a slot.
    assign in_use    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = (state == FETCH) && !reset && (in_use < DEPTH_SUM);
    assign imem_addr = fetch_ptr;

    assign grant           = imem_req && imem_gnt;
    assign resp_tag        = tag_mem[tag_rd];
    assign resp_keep       = imem_rvalid && !redirect && (drop_cnt == '0);
    assign outstanding_nxt = outstanding + CW'(grant) - CW'(imem_rvalid);

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_keep && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (count != '0) begin
            out_valid = 1'b1;
            out_pc    = q_pc[q_rd];
            out_instr = q_instr[q_rd];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_pc    = resp_tag;
            out_instr = imem_rdata;
        end
    end

    assign pop_q = (count != '0) && out_ready;
    assign enq   = resp_keep && !(bypass && out_ready);

    // Redirect squashes the queue and marks every request still in flight (including this cycle's grant) for drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            fetch_ptr   <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            case (state)
                FETCH:   if (halt)  state <= HALTED;
                HALTED:  if (!halt) state <= FETCH;
                default: state <= FETCH;
            endcase

            if (grant) begin
                tag_mem[tag_wr] <= fetch_ptr;
                tag_wr          <= tag_wr + AW'(1);
            end
            if (imem_rvalid) begin
                tag_rd <= tag_rd + AW'(1);
            end
            outstanding <= outstanding_nxt;

            if (enq) begin
                q_pc[q_wr]    <= resp_tag;
                q_instr[q_wr] <= imem_rdata;
            end

            if (redirect) begin
                fetch_ptr <= redirect_pc;
                drop_cnt  <= outstanding_nxt;
                count     <= '0;
                q_rd      <= '0;
                q_wr      <= '0;
            end else begin
                if (grant) begin
                    fetch_ptr <= fetch_ptr + 32'd1;
                end
                if (imem_rvalid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (enq) begin
                    q_wr <= q_wr + AW'(1);
                end
                if (pop_q) begin
                    q_rd <= q_rd + AW'(1);
                end
                count <= count + CW'(enq) - CW'(pop_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(enq && (count == DEPTH_CNT) && !pop_q));
            assert (!(imem_rvalid && (outstanding == '0)));
        end
    end

endmodule
